// File: rtl/frame_diff_buf_sched.sv
// Reference-frame store scheduler: shares one memory command port between current-frame
// write-back and reference-frame prefetch, rotating bank pointers on every frame start.
module frame_diff_buf_sched #(
    parameter int FRAME_GAP   = 1,
    parameter int FRAME_WORDS = 307200,
    parameter int BURST_LEN   = 64,
    parameter int ADDR_W      = 24,
    parameter int RD_DEPTH    = 512,
    parameter int RD_URGENT   = 128,
    parameter int LVL_W       = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pre_img_vsync,
    input  logic [LVL_W-1:0]  wr_level,
    input  logic [LVL_W-1:0]  rd_level,
    input  logic              mem_rd_beat,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_wr,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic              diff_en,
    output logic              frame_err
);

    localparam int NBANK  = FRAME_GAP + 1;
    localparam int NBURST = FRAME_WORDS / BURST_LEN;
    localparam int CNT_W  = $clog2(NBURST + 1);
    localparam int DEP_W  = $clog2(RD_DEPTH + 1);
    localparam int RSV_W  = ((LVL_W > DEP_W) ? LVL_W : DEP_W) + 1;

    localparam logic [1:0]        S_IDLE    = 2'd0;
    localparam logic [1:0]        S_ARB     = 2'd1;
    localparam logic [1:0]        S_ISSUE   = 2'd2;
    localparam logic [1:0]        BANK_MAX  = 2'(NBANK - 1);
    localparam logic [1:0]        FG_C      = 2'(FRAME_GAP);
    localparam logic [CNT_W-1:0]  NBURST_C  = CNT_W'(NBURST);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [LVL_W-1:0]  BL_LVL    = LVL_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] BL_A      = ADDR_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] FW_A      = ADDR_W'(FRAME_WORDS);
    localparam logic [RSV_W-1:0]  RSV_BL    = RSV_W'(BURST_LEN);
    localparam logic [RSV_W-1:0]  RSV_ONE   = RSV_W'(1);
    localparam logic [RSV_W-1:0]  RSV_RDMAX = RSV_W'(RD_DEPTH - BURST_LEN);
    localparam logic [RSV_W-1:0]  RSV_URG   = RSV_W'(RD_URGENT);

    function automatic logic [1:0] bank_inc(input logic [1:0] b);
        return (b == BANK_MAX) ? 2'd0 : b + 2'd1;
    endfunction

    logic              vsync_q, vsync_d;
    logic [1:0]        state_q, state_d;
    logic [1:0]        wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [ADDR_W-1:0] wr_off_q, wr_off_d, rd_off_q, rd_off_d;
    logic [CNT_W-1:0]  wr_left_q, wr_left_d, rd_left_q, rd_left_d;
    logic [1:0]        frames_q, frames_d;
    logic [RSV_W-1:0]  inflight_q, inflight_d;
    logic              last_wr_q, last_wr_d;
    logic              stale_q, stale_d;
    logic              cmd_valid_q, cmd_valid_d, cmd_wr_q, cmd_wr_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic              diff_en_q, diff_en_d, frame_err_q, frame_err_d;

    logic              fs_s, accept_s, wr_elig_s, rd_elig_s, grant_s, grant_rd_s;
    logic [RSV_W-1:0]  rsv_s;
    logic [ADDR_W-1:0] wr_base_s, rd_base_s;

    // Next-state logic: arbitration, command issue and frame-start rotation.
    always_comb begin
        vsync_d     = pre_img_vsync;
        state_d     = state_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        wr_off_d    = wr_off_q;
        rd_off_d    = rd_off_q;
        wr_left_d   = wr_left_q;
        rd_left_d   = rd_left_q;
        frames_d    = frames_q;
        last_wr_d   = last_wr_q;
        stale_d     = stale_q;
        cmd_valid_d = cmd_valid_q;
        cmd_wr_d    = cmd_wr_q;
        cmd_addr_d  = cmd_addr_q;
        diff_en_d   = diff_en_q;
        frame_err_d = 1'b0;
        grant_s     = 1'b0;
        grant_rd_s  = 1'b0;

        fs_s      = pre_img_vsync & ~vsync_q;
        accept_s  = cmd_valid_q & cmd_ready;
        rsv_s     = RSV_W'(rd_level) + inflight_q;
        wr_elig_s = (wr_left_q != '0) && (wr_level >= BL_LVL);
        rd_elig_s = diff_en_q && (rd_left_q != '0) && (rsv_s <= RSV_RDMAX);
        wr_base_s = {{(ADDR_W-2){1'b0}}, wr_bank_q} * FW_A;
        rd_base_s = {{(ADDR_W-2){1'b0}}, rd_bank_q} * FW_A;

        // Read beats still arrive for stale or discarded reads, so this counts every acceptance.
        inflight_d = inflight_q + ((accept_s && !cmd_wr_q) ? RSV_BL : '0)
                                - (mem_rd_beat ? RSV_ONE : '0);

        case (state_q)
            S_IDLE: begin
                state_d = fs_s ? S_ARB : S_IDLE;
            end
            S_ARB: begin
                if (fs_s) begin
                    grant_s = 1'b0;
                end else if (rd_elig_s && (rsv_s < RSV_URG)) begin
                    grant_s    = 1'b1;
                    grant_rd_s = 1'b1;
                end else if (rd_elig_s && wr_elig_s) begin
                    grant_s    = 1'b1;
                    grant_rd_s = last_wr_q;
                end else if (rd_elig_s || wr_elig_s) begin
                    grant_s    = 1'b1;
                    grant_rd_s = rd_elig_s;
                end else begin
                    grant_s = 1'b0;
                end
                if (grant_s) begin
                    cmd_valid_d = 1'b1;
                    cmd_wr_d    = ~grant_rd_s;
                    cmd_addr_d  = grant_rd_s ? (rd_base_s + rd_off_q) : (wr_base_s + wr_off_q);
                    last_wr_d   = ~grant_rd_s;
                    state_d     = S_ISSUE;
                end else begin
                    state_d = S_ARB;
                end
            end
            S_ISSUE: begin
                if (accept_s) begin
                    cmd_valid_d = 1'b0;
                    stale_d     = 1'b0;
                    state_d     = S_ARB;
                    if (stale_q || fs_s) begin
                        wr_left_d = wr_left_q;
                    end else if (cmd_wr_q) begin
                        wr_left_d = wr_left_q - CNT_ONE;
                        wr_off_d  = wr_off_q + BL_A;
                    end else begin
                        rd_left_d = rd_left_q - CNT_ONE;
                        rd_off_d  = rd_off_q + BL_A;
                    end
                end else begin
                    state_d = S_ISSUE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Leaving IDLE only loads the counters; later frame starts also rotate and audit.
        if (fs_s && (state_q != S_IDLE)) begin
            wr_bank_d   = bank_inc(wr_bank_q);
            rd_bank_d   = bank_inc(bank_inc(wr_bank_q));
            frame_err_d = (wr_left_q != '0) || (diff_en_q && (rd_left_q != '0));
            frames_d    = ((wr_left_q == '0) && (frames_q != FG_C)) ? frames_q + 2'd1 : frames_q;
            stale_d     = (state_q == S_ISSUE) && !accept_s;
        end else begin
            frame_err_d = 1'b0;
        end
        if (fs_s) begin
            wr_off_d  = '0;
            rd_off_d  = '0;
            wr_left_d = NBURST_C;
            rd_left_d = NBURST_C;
            diff_en_d = (frames_d == FG_C);
        end else begin
            diff_en_d = diff_en_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q     <= 1'b0;
            state_q     <= S_IDLE;
            wr_bank_q   <= 2'd0;
            rd_bank_q   <= 2'(1 % NBANK);
            wr_off_q    <= '0;
            rd_off_q    <= '0;
            wr_left_q   <= '0;
            rd_left_q   <= '0;
            frames_q    <= 2'd0;
            inflight_q  <= '0;
            last_wr_q   <= 1'b1;
            stale_q     <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_wr_q    <= 1'b0;
            cmd_addr_q  <= '0;
            diff_en_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            vsync_q     <= vsync_d;
            state_q     <= state_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_off_q    <= wr_off_d;
            rd_off_q    <= rd_off_d;
            wr_left_q   <= wr_left_d;
            rd_left_q   <= rd_left_d;
            frames_q    <= frames_d;
            inflight_q  <= inflight_d;
            last_wr_q   <= last_wr_d;
            stale_q     <= stale_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_wr_q    <= cmd_wr_d;
            cmd_addr_q  <= cmd_addr_d;
            diff_en_q   <= diff_en_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_wr    = cmd_wr_q;
    assign cmd_addr  = cmd_addr_q;
    assign diff_en   = diff_en_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_frame_diff_buf_sched.sv
// Bench for frame_diff_buf_sched: dut A (FRAME_GAP=1) runs a table of frames, dut B
// (FRAME_GAP=2, RD_DEPTH=8) runs hand-written corner sequences; commands go through scoreboards.
module tb_frame_diff_buf_sched;

    typedef struct packed {
        logic        wr;
        logic [23:0] addr;
    } cmd_t;

    typedef struct packed {
        logic [9:0]      wl;
        logic [9:0]      rl;
        logic            de;
        logic            fe;
        logic [3:0]      n;
        logic [7:0][8:0] cmds;
    } row_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_vs, a_beat, a_rdy, a_cv, a_cw, a_de, a_fe;
    logic [9:0]  a_wl, a_rl;
    logic [23:0] a_ca;
    logic        b_vs, b_beat, b_rdy, b_cv, b_cw, b_de, b_fe;
    logic [9:0]  b_wl, b_rl;
    logic [23:0] b_ca;

    int   checks = 0;
    int   failures = 0;
    cmd_t qa[$];
    cmd_t qb[$];
    row_t rows [5];

    always #5 clk = ~clk;

    frame_diff_buf_sched #(.FRAME_GAP(1), .FRAME_WORDS(16), .BURST_LEN(4), .ADDR_W(24),
                           .RD_DEPTH(512), .RD_URGENT(128), .LVL_W(10)) dut_a (
        .clk(clk), .rst(rst), .pre_img_vsync(a_vs), .wr_level(a_wl), .rd_level(a_rl),
        .mem_rd_beat(a_beat), .cmd_valid(a_cv), .cmd_ready(a_rdy), .cmd_wr(a_cw),
        .cmd_addr(a_ca), .diff_en(a_de), .frame_err(a_fe));

    frame_diff_buf_sched #(.FRAME_GAP(2), .FRAME_WORDS(16), .BURST_LEN(4), .ADDR_W(24),
                           .RD_DEPTH(8), .RD_URGENT(128), .LVL_W(10)) dut_b (
        .clk(clk), .rst(rst), .pre_img_vsync(b_vs), .wr_level(b_wl), .rd_level(b_rl),
        .mem_rd_beat(b_beat), .cmd_valid(b_cv), .cmd_ready(b_rdy), .cmd_wr(b_cw),
        .cmd_addr(b_ca), .diff_en(b_de), .frame_err(b_fe));

    function automatic logic [8:0] c(input logic w, input int a);
        return {w, 8'(a)};
    endfunction

    function automatic cmd_t e(input logic w, input int a);
        return {w, 24'(a)};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic sb_check(input int which, input cmd_t got);
        cmd_t exp;
        checks++;
        if (((which == 0) ? qa.size() : qb.size()) == 0) begin
            failures++;
            $display("FAIL %s_cmd got=%0h exp=none", (which == 0) ? "a" : "b", got);
        end else begin
            exp = (which == 0) ? qa.pop_front() : qb.pop_front();
            if (got !== exp) begin
                failures++;
                $display("FAIL %s_cmd got=%0h exp=%0h", (which == 0) ? "a" : "b", got, exp);
            end
        end
    endtask

    // One clock: acceptance is decided by the values held up to the edge, outputs read 1 ns after.
    task automatic step();
        logic acc_a, acc_b;
        cmd_t ca, cb;
        acc_a = a_cv && a_rdy;
        acc_b = b_cv && b_rdy;
        ca = {a_cw, a_ca};
        cb = {b_cw, b_ca};
        @(posedge clk);
        #1;
        if (acc_a) sb_check(0, ca);
        if (acc_b) sb_check(1, cb);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drain(input int which, input int budget);
        int n;
        n = 0;
        while ((((which == 0) ? qa.size() : qb.size()) != 0) && (n < budget)) begin
            step();
            n++;
        end
        chk((which == 0) ? "a_drain_left" : "b_drain_left", (which == 0) ? qa.size() : qb.size(), 0);
    endtask

    task automatic b_frame(input logic [9:0] wl, input logic [9:0] rl, input logic de, input logic fe);
        b_wl = wl;
        b_rl = rl;
        b_vs = 1'b1;
        step();
        chk("b_diff_en_fs", b_de, de);
        chk("b_frame_err_fs", b_fe, fe);
        b_vs = 1'b0;
        step();
        chk("b_frame_err_after", b_fe, 0);
    endtask

    initial begin
        int n;
        rows[0] = '{wl:10'd16, rl:10'd0, de:1'b0, fe:1'b0, n:4'd4,
                    cmds:{9'h0, 9'h0, 9'h0, 9'h0, c(1,12), c(1,8), c(1,4), c(1,0)}};
        rows[1] = '{wl:10'd16, rl:10'd200, de:1'b1, fe:1'b0, n:4'd8,
                    cmds:{c(1,28), c(0,12), c(1,24), c(0,8), c(1,20), c(0,4), c(1,16), c(0,0)}};
        rows[2] = '{wl:10'd16, rl:10'd0, de:1'b1, fe:1'b0, n:4'd8,
                    cmds:{c(1,12), c(1,8), c(1,4), c(1,0), c(0,28), c(0,24), c(0,20), c(0,16)}};
        rows[3] = '{wl:10'd0, rl:10'd200, de:1'b1, fe:1'b0, n:4'd4,
                    cmds:{9'h0, 9'h0, 9'h0, 9'h0, c(0,12), c(0,8), c(0,4), c(0,0)}};
        rows[4] = '{wl:10'd16, rl:10'd200, de:1'b1, fe:1'b1, n:4'd8,
                    cmds:{c(0,28), c(1,12), c(0,24), c(1,8), c(0,20), c(1,4), c(0,16), c(1,0)}};

        rst = 1'b1;
        a_vs = 1'b0; a_wl = '0; a_rl = '0; a_beat = 1'b0; a_rdy = 1'b1;
        b_vs = 1'b0; b_wl = '0; b_rl = '0; b_beat = 1'b0; b_rdy = 1'b1;
        idle(3);
        chk("a_rst_cmd_valid", a_cv, 0);
        chk("a_rst_cmd_wr", a_cw, 0);
        chk("a_rst_cmd_addr", a_ca, 0);
        chk("a_rst_diff_en", a_de, 0);
        chk("b_rst_frame_err", b_fe, 0);
        rst = 1'b0;
        idle(3);
        chk("a_idle_no_cmd", a_cv, 0);

        // Table of frames for dut A: levels are applied on the frame-start edge itself.
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < int'(rows[r].n); k++)
                qa.push_back({rows[r].cmds[k][8], 16'h0, rows[r].cmds[k][7:0]});
            a_wl = rows[r].wl;
            a_rl = rows[r].rl;
            a_vs = 1'b1;
            step();
            chk("a_diff_en_fs", a_de, rows[r].de);
            chk("a_frame_err_fs", a_fe, rows[r].fe);
            a_vs = 1'b0;
            step();
            chk("a_frame_err_after", a_fe, 0);
            drain(0, 60);
            idle(4);
        end

        // dut B: banks 0 -> 1 -> 2 -> 0, with a short second frame delaying diff_en.
        qb.push_back(e(1,0)); qb.push_back(e(1,4)); qb.push_back(e(1,8)); qb.push_back(e(1,12));
        b_frame(10'd16, 10'd0, 1'b0, 1'b0);
        drain(1, 40);
        idle(3);
        qb.push_back(e(1,16)); qb.push_back(e(1,20));
        b_frame(10'd16, 10'd0, 1'b0, 1'b0);
        drain(1, 40);
        b_wl = '0;
        idle(6);
        qb.push_back(e(1,32)); qb.push_back(e(1,36)); qb.push_back(e(1,40)); qb.push_back(e(1,44));
        b_frame(10'd16, 10'd0, 1'b0, 1'b1);
        drain(1, 40);
        idle(3);

        // Read flow control: two reads fill the 8-word FIFO budget, four beats allow one more.
        qb.push_back(e(0,16)); qb.push_back(e(0,20));
        b_frame(10'd0, 10'd0, 1'b1, 1'b0);
        drain(1, 40);
        idle(10);
        chk("b_rd_blocked", b_cv, 0);
        qb.push_back(e(0,24));
        b_beat = 1'b1;
        idle(4);
        b_beat = 1'b0;
        drain(1, 20);
        idle(6);

        // Backpressure: the presented write stays frozen while cmd_ready is low.
        b_rdy = 1'b0;
        b_wl = 10'd16;
        n = 0;
        while (!b_cv && (n < 20)) begin
            step();
            n++;
        end
        chk("b_bp_valid_up", b_cv, 1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("b_bp_valid", b_cv, 1);
            chk("b_bp_wr", b_cw, 1);
            chk("b_bp_addr", b_ca, 0);
        end
        qb.push_back(e(1,0)); qb.push_back(e(1,4));
        b_rdy = 1'b1;
        drain(1, 20);
        b_rdy = 1'b0;
        step();
        chk("b_issue_valid", b_cv, 1);
        chk("b_issue_addr", b_ca, 8);

        // Reset while a command is held in ISSUE.
        rst = 1'b1;
        step();
        chk("b_rst_issue_valid", b_cv, 0);
        chk("b_rst_issue_diff_en", b_de, 0);
        rst = 1'b0;
        b_rdy = 1'b1;
        idle(3);
        chk("b_post_rst_valid", b_cv, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
